// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor resolve queue.
// domain_t normally lives in common_defines.svh; it is declared here so this slice is self-contained.
package bp_pkg;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        USER    = 2'd1,
        SUPER   = 2'd2,
        MACHINE = 2'd3
    } domain_t;

    typedef struct packed {
        logic [31:0] idx;
        logic        pred;
        logic [31:0] targ;
        domain_t     domain;
    } bprq_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } bprq_state_e;

    localparam int unsigned BR_INSN_BYTES = 4;

    // Sequential fetch address following a branch; wraps modulo 2^32.
    function automatic logic [31:0] bprq_fallthrough(input logic [31:0] pc);
        return pc + 32'(BR_INSN_BYTES);
    endfunction

endpackage

// File: rtl/bprq_storage.sv
// Prediction record array: one synchronous write port, combinational head read port.
// Data is intentionally not reset; validity is tracked by the queue pointers.
module bprq_storage
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  bprq_entry_t      wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output bprq_entry_t      rdata_o
);

    bprq_entry_t r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/bp_resolve_queue.sv
// In-order prediction record queue producing the TAGE training stream and mispredict redirects.
// Optional BPRQ_DOMAIN_BARRIER_EN: stall allocs from a new domain until the queue drains.
module bp_resolve_queue
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       alloc_valid_i,
    output logic                       alloc_ready_o,
    input  logic [31:0]                alloc_idx_i,
    input  logic                       alloc_pred_i,
    input  logic [31:0]                alloc_targ_i,
    input  domain_t                    alloc_domain_i,
    input  logic                       res_valid_i,
    output logic                       res_ready_o,
    input  logic                       res_taken_i,
    input  logic [31:0]                res_targ_i,
    output logic                       upd_valid_o,
    output logic                       br_result_o,
    output logic                       correct_o,
    output logic [31:0]                idx_o,
    output domain_t                    domain_o,
    output logic                       redirect_o,
    output logic [31:0]                redirect_pc_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [CNT_W-1:0]           mispred_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    bprq_state_e      r_state, w_state_nxt;
    logic [PTR_W-1:0] r_head, w_head_nxt;
    logic [PTR_W-1:0] r_tail, w_tail_nxt;
    logic [CW-1:0]    r_count, w_count_nxt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic             r_upd_valid;
    logic             r_br_result;
    logic             r_correct;
    logic [31:0]      r_idx;
    domain_t          r_domain;
    logic             r_redirect;
    logic [31:0]      r_redirect_pc;

    bprq_entry_t      w_head_entry;
    bprq_entry_t      w_alloc_entry;
    logic             w_base_ready;
    logic             w_alloc_ready;
    logic             w_res_ready;
    logic             w_alloc_fire;
    logic             w_res_fire;
    logic             w_correct;
    logic             w_mispred;
    logic             w_wr_en;

    assign w_base_ready = (r_state == RUN) && (r_count < FULL_C);
    assign w_res_ready  = (r_state == RUN) && (r_count != '0);

`ifdef BPRQ_DOMAIN_BARRIER_EN
    domain_t r_last_domain;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last_domain <= INIT;
        end else if (w_wr_en) begin
            r_last_domain <= alloc_domain_i;
        end
    end

    // An empty queue always accepts, so a new domain only waits for the old one to drain.
    assign w_alloc_ready = w_base_ready &&
                           ((r_count == '0) || (alloc_domain_i == r_last_domain));
`else
    assign w_alloc_ready = w_base_ready;
`endif

    assign w_alloc_fire = alloc_valid_i && w_alloc_ready;
    assign w_res_fire   = res_valid_i && w_res_ready;

    assign w_correct = (w_head_entry.pred == res_taken_i) &&
                       (!res_taken_i || (w_head_entry.targ == res_targ_i));
    assign w_mispred = w_res_fire && !w_correct;

    // A same-cycle alloc is younger than the mispredicted branch and must not land.
    assign w_wr_en = w_alloc_fire && !w_mispred;

    assign w_alloc_entry = '{idx: alloc_idx_i, pred: alloc_pred_i,
                             targ: alloc_targ_i, domain: alloc_domain_i};

    bprq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk_i   (clk_i),
        .we_i    (w_wr_en),
        .waddr_i (r_tail),
        .wdata_i (w_alloc_entry),
        .raddr_i (r_head),
        .rdata_o (w_head_entry)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= RUN;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_count_nxt = r_count;
        case (r_state)
            RUN: begin
                if (w_mispred) begin
                    w_state_nxt = FLUSH;
                    w_head_nxt  = '0;
                    w_tail_nxt  = '0;
                    w_count_nxt = '0;
                end else begin
                    if (w_alloc_fire) begin
                        w_tail_nxt = r_tail + PTR_W'(1);
                    end
                    if (w_res_fire) begin
                        w_head_nxt = r_head + PTR_W'(1);
                    end
                    if (w_alloc_fire && !w_res_fire) begin
                        w_count_nxt = r_count + CW'(1);
                    end else if (!w_alloc_fire && w_res_fire) begin
                        w_count_nxt = r_count - CW'(1);
                    end
                end
            end
            FLUSH: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_upd_valid   <= 1'b0;
            r_br_result   <= 1'b0;
            r_correct     <= 1'b0;
            r_idx         <= '0;
            r_domain      <= INIT;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_upd_valid <= w_res_fire;
            r_redirect  <= w_mispred;
            if (w_res_fire) begin
                r_br_result <= res_taken_i;
                r_correct   <= w_correct;
                r_idx       <= w_head_entry.idx;
                r_domain    <= w_head_entry.domain;
            end
            if (w_mispred) begin
                r_redirect_pc <= res_taken_i ? res_targ_i
                                             : bprq_fallthrough(w_head_entry.idx);
                if (r_mispred_cnt != '1) begin
                    r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign alloc_ready_o = w_alloc_ready;
    assign res_ready_o   = w_res_ready;
    assign upd_valid_o   = r_upd_valid;
    assign br_result_o   = r_br_result;
    assign correct_o     = r_correct;
    assign idx_o         = r_idx;
    assign domain_o      = r_domain;
    assign redirect_o    = r_redirect;
    assign redirect_pc_o = r_redirect_pc;
    assign count_o       = r_count;
    assign mispred_cnt_o = r_mispred_cnt;

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed self-checking bench for bp_resolve_queue (DEPTH=8, CNT_W=16).
// The barrier scenario follows BPRQ_DOMAIN_BARRIER_EN when it is defined for the build.
module tb_bp_resolve_queue;
    import bp_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        alloc_valid_i;
    logic        alloc_ready_o;
    logic [31:0] alloc_idx_i;
    logic        alloc_pred_i;
    logic [31:0] alloc_targ_i;
    domain_t     alloc_domain_i;
    logic        res_valid_i;
    logic        res_ready_o;
    logic        res_taken_i;
    logic [31:0] res_targ_i;
    logic        upd_valid_o;
    logic        br_result_o;
    logic        correct_o;
    logic [31:0] idx_o;
    domain_t     domain_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic [3:0]  count_o;
    logic [15:0] mispred_cnt_o;

    int total = 0;
    int bad   = 0;

    bp_resolve_queue #(
        .DEPTH (8),
        .CNT_W (16)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .alloc_valid_i  (alloc_valid_i),
        .alloc_ready_o  (alloc_ready_o),
        .alloc_idx_i    (alloc_idx_i),
        .alloc_pred_i   (alloc_pred_i),
        .alloc_targ_i   (alloc_targ_i),
        .alloc_domain_i (alloc_domain_i),
        .res_valid_i    (res_valid_i),
        .res_ready_o    (res_ready_o),
        .res_taken_i    (res_taken_i),
        .res_targ_i     (res_targ_i),
        .upd_valid_o    (upd_valid_o),
        .br_result_o    (br_result_o),
        .correct_o      (correct_o),
        .idx_o          (idx_o),
        .domain_o       (domain_o),
        .redirect_o     (redirect_o),
        .redirect_pc_o  (redirect_pc_o),
        .count_o        (count_o),
        .mispred_cnt_o  (mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle();
        alloc_valid_i  = 1'b0;
        alloc_idx_i    = '0;
        alloc_pred_i   = 1'b0;
        alloc_targ_i   = '0;
        alloc_domain_i = INIT;
        res_valid_i    = 1'b0;
        res_taken_i    = 1'b0;
        res_targ_i     = '0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Offer one record and wait (bounded) for the handshake.
    task automatic do_alloc(input logic [31:0] pc, input logic pred,
                            input logic [31:0] targ, input domain_t d);
        bit done = 0;
        alloc_valid_i  = 1'b1;
        alloc_idx_i    = pc;
        alloc_pred_i   = pred;
        alloc_targ_i   = targ;
        alloc_domain_i = d;
        #1;
        for (int n = 0; n < 20 && !done; n++) begin
            done = alloc_ready_o;
            tick();
        end
        alloc_valid_i = 1'b0;
        if (!done) begin
            bad++;
            $display("FAIL alloc_timeout pc=%h got ready=0 want ready=1", pc);
        end
        total++;
    endtask

    task automatic do_resolve(input logic taken, input logic [31:0] targ);
        bit done = 0;
        res_valid_i = 1'b1;
        res_taken_i = taken;
        res_targ_i  = targ;
        #1;
        for (int n = 0; n < 20 && !done; n++) begin
            done = res_ready_o;
            tick();
        end
        res_valid_i = 1'b0;
        if (!done) begin
            bad++;
            $display("FAIL resolve_timeout got ready=0 want ready=1");
        end
        total++;
    endtask

    task automatic test_reset();
        idle();
        rst_i = 1'b1;
        tick();
        tick();
        total++; if (count_o !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count_o); end
        total++; if (upd_valid_o !== 1'b0 || redirect_o !== 1'b0) begin bad++; $display("FAIL rst_strobes got upd=%b redir=%b want 0 0", upd_valid_o, redirect_o); end
        total++; if (idx_o !== 32'h0 || redirect_pc_o !== 32'h0 || br_result_o !== 1'b0 || correct_o !== 1'b0) begin bad++; $display("FAIL rst_data got idx=%h rpc=%h br=%b c=%b want zeros", idx_o, redirect_pc_o, br_result_o, correct_o); end
        total++; if (domain_o !== INIT) begin bad++; $display("FAIL rst_domain got=%0d want=%0d", domain_o, INIT); end
        total++; if (mispred_cnt_o !== 16'd0) begin bad++; $display("FAIL rst_mispred got=%0d want=0", mispred_cnt_o); end
        rst_i = 1'b0;
        #1;
        total++; if (alloc_ready_o !== 1'b1 || res_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready got a=%b r=%b want 1 0", alloc_ready_o, res_ready_o); end
    endtask

    task automatic test_in_order();
        do_alloc(32'h100, 1'b1, 32'h1000, USER);
        do_alloc(32'h200, 1'b0, 32'h0,    SUPER);
        do_alloc(32'h300, 1'b1, 32'h3000, USER);
        total++; if (count_o !== 4'd3) begin bad++; $display("FAIL io_count3 got=%0d want=3", count_o); end
        do_resolve(1'b1, 32'h1000);
        total++; if (upd_valid_o !== 1'b1 || idx_o !== 32'h100 || correct_o !== 1'b1 || br_result_o !== 1'b1 || domain_o !== USER) begin bad++; $display("FAIL io_upd0 got v=%b idx=%h c=%b br=%b d=%0d want 1 100 1 1 1", upd_valid_o, idx_o, correct_o, br_result_o, domain_o); end
        total++; if (redirect_o !== 1'b0 || count_o !== 4'd2) begin bad++; $display("FAIL io_state0 got redir=%b cnt=%0d want 0 2", redirect_o, count_o); end
        do_resolve(1'b0, 32'h0);
        total++; if (upd_valid_o !== 1'b1 || idx_o !== 32'h200 || correct_o !== 1'b1 || br_result_o !== 1'b0 || domain_o !== SUPER) begin bad++; $display("FAIL io_upd1 got v=%b idx=%h c=%b br=%b d=%0d want 1 200 1 0 2", upd_valid_o, idx_o, correct_o, br_result_o, domain_o); end
        do_resolve(1'b1, 32'h3000);
        total++; if (upd_valid_o !== 1'b1 || idx_o !== 32'h300 || correct_o !== 1'b1 || redirect_o !== 1'b0) begin bad++; $display("FAIL io_upd2 got v=%b idx=%h c=%b redir=%b want 1 300 1 0", upd_valid_o, idx_o, correct_o, redirect_o); end
        total++; if (count_o !== 4'd0) begin bad++; $display("FAIL io_count0 got=%0d want=0", count_o); end
        tick();
        total++; if (upd_valid_o !== 1'b0 || idx_o !== 32'h300 || redirect_o !== 1'b0) begin bad++; $display("FAIL io_hold got v=%b idx=%h redir=%b want 0 300 0", upd_valid_o, idx_o, redirect_o); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) do_alloc(32'h1000 + 32'(i * 4), 1'b0, 32'h0, USER);
        alloc_domain_i = USER;
        #1;
        total++; if (count_o !== 4'd8 || alloc_ready_o !== 1'b0) begin bad++; $display("FAIL full_count got cnt=%0d ready=%b want 8 0", count_o, alloc_ready_o); end
        alloc_valid_i = 1'b1;
        alloc_idx_i   = 32'h2000;
        alloc_pred_i  = 1'b0;
        alloc_targ_i  = 32'h0;
        res_valid_i   = 1'b1;
        res_taken_i   = 1'b0;
        #1;
        total++; if (alloc_ready_o !== 1'b0) begin bad++; $display("FAIL full_pop_cycle got ready=%b want 0", alloc_ready_o); end
        tick();
        res_valid_i = 1'b0;
        #1;
        total++; if (count_o !== 4'd7 || alloc_ready_o !== 1'b1 || idx_o !== 32'h1000) begin bad++; $display("FAIL full_after_pop got cnt=%0d ready=%b idx=%h want 7 1 1000", count_o, alloc_ready_o, idx_o); end
        tick();
        alloc_valid_i = 1'b0;
        total++; if (count_o !== 4'd8) begin bad++; $display("FAIL full_refill got=%0d want=8", count_o); end
        for (int i = 0; i < 8; i++) do_resolve(1'b0, 32'h0);
        total++; if (idx_o !== 32'h2000 || correct_o !== 1'b1 || count_o !== 4'd0) begin bad++; $display("FAIL full_drain got idx=%h c=%b cnt=%0d want 2000 1 0", idx_o, correct_o, count_o); end
    endtask

    task automatic test_mispredict_dir();
        do_alloc(32'h400, 1'b1, 32'h800, USER);
        for (int i = 1; i < 4; i++) do_alloc(32'h400 + 32'(i * 4), 1'b0, 32'h0, USER);
        do_resolve(1'b0, 32'h0);
        total++; if (upd_valid_o !== 1'b1 || correct_o !== 1'b0 || br_result_o !== 1'b0 || idx_o !== 32'h400) begin bad++; $display("FAIL md_upd got v=%b c=%b br=%b idx=%h want 1 0 0 400", upd_valid_o, correct_o, br_result_o, idx_o); end
        total++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h404) begin bad++; $display("FAIL md_redirect got r=%b pc=%h want 1 404", redirect_o, redirect_pc_o); end
        total++; if (count_o !== 4'd0 || alloc_ready_o !== 1'b0 || res_ready_o !== 1'b0) begin bad++; $display("FAIL md_flush got cnt=%0d a=%b r=%b want 0 0 0", count_o, alloc_ready_o, res_ready_o); end
        total++; if (mispred_cnt_o !== 16'd1) begin bad++; $display("FAIL md_cnt got=%0d want=1", mispred_cnt_o); end
        tick();
        total++; if (redirect_o !== 1'b0 || upd_valid_o !== 1'b0 || alloc_ready_o !== 1'b1 || redirect_pc_o !== 32'h404) begin bad++; $display("FAIL md_run got r=%b v=%b a=%b pc=%h want 0 0 1 404", redirect_o, upd_valid_o, alloc_ready_o, redirect_pc_o); end
    endtask

    task automatic test_mispredict_targ();
        do_alloc(32'h500, 1'b1, 32'h800, USER);
        do_alloc(32'h504, 1'b0, 32'h0,   USER);
        alloc_valid_i  = 1'b1;
        alloc_idx_i    = 32'h600;
        alloc_pred_i   = 1'b0;
        alloc_targ_i   = 32'h0;
        alloc_domain_i = USER;
        res_valid_i    = 1'b1;
        res_taken_i    = 1'b1;
        res_targ_i     = 32'h900;
        #1;
        total++; if (alloc_ready_o !== 1'b1) begin bad++; $display("FAIL mt_alloc_hs got ready=%b want 1", alloc_ready_o); end
        tick();
        idle();
        total++; if (correct_o !== 1'b0 || br_result_o !== 1'b1 || redirect_o !== 1'b1 || redirect_pc_o !== 32'h900) begin bad++; $display("FAIL mt_redirect got c=%b br=%b r=%b pc=%h want 0 1 1 900", correct_o, br_result_o, redirect_o, redirect_pc_o); end
        total++; if (count_o !== 4'd0 || mispred_cnt_o !== 16'd2) begin bad++; $display("FAIL mt_count got cnt=%0d mc=%0d want 0 2", count_o, mispred_cnt_o); end
        tick();
        total++; if (count_o !== 4'd0) begin bad++; $display("FAIL mt_dropped got=%0d want=0", count_o); end
        do_alloc(32'h700, 1'b0, 32'h0, MACHINE);
        do_resolve(1'b0, 32'h0);
        total++; if (idx_o !== 32'h700 || domain_o !== MACHINE || correct_o !== 1'b1) begin bad++; $display("FAIL mt_next got idx=%h d=%0d c=%b want 700 3 1", idx_o, domain_o, correct_o); end
    endtask

    task automatic test_wrap();
        do_alloc(32'hFFFF_FFFC, 1'b1, 32'h10, USER);
        do_resolve(1'b0, 32'h0);
        total++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h0 || mispred_cnt_o !== 16'd3) begin bad++; $display("FAIL wrap got r=%b pc=%h mc=%0d want 1 0 3", redirect_o, redirect_pc_o, mispred_cnt_o); end
        tick();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) do_alloc(32'h800 + 32'(i * 4), 1'b0, 32'h0, USER);
        total++; if (count_o !== 4'd5) begin bad++; $display("FAIL ar_count5 got=%0d want=5", count_o); end
        #3;
        rst_i = 1'b1;
        #1;
        total++; if (count_o !== 4'd0 || mispred_cnt_o !== 16'd0) begin bad++; $display("FAIL ar_count got cnt=%0d mc=%0d want 0 0", count_o, mispred_cnt_o); end
        total++; if (upd_valid_o !== 1'b0 || redirect_o !== 1'b0 || idx_o !== 32'h0 || redirect_pc_o !== 32'h0 || domain_o !== INIT) begin bad++; $display("FAIL ar_outputs got v=%b r=%b idx=%h pc=%h d=%0d want zeros", upd_valid_o, redirect_o, idx_o, redirect_pc_o, domain_o); end
        tick();
        rst_i       = 1'b0;
        res_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (res_ready_o !== 1'b0 || count_o !== 4'd0) begin bad++; $display("FAIL ar_ready%0d got r=%b cnt=%0d want 0 0", i, res_ready_o, count_o); end
            tick();
            total++; if (upd_valid_o !== 1'b0) begin bad++; $display("FAIL ar_noupd%0d got=%b want=0", i, upd_valid_o); end
        end
        res_valid_i = 1'b0;
    endtask

    task automatic test_domain_barrier();
        do_alloc(32'h900, 1'b0, 32'h0, USER);
        do_alloc(32'h904, 1'b0, 32'h0, USER);
        alloc_valid_i  = 1'b1;
        alloc_idx_i    = 32'hA00;
        alloc_pred_i   = 1'b0;
        alloc_targ_i   = 32'h0;
        alloc_domain_i = SUPER;
        #1;
`ifdef BPRQ_DOMAIN_BARRIER_EN
        total++; if (alloc_ready_o !== 1'b0) begin bad++; $display("FAIL db_stall got ready=%b want 0", alloc_ready_o); end
        res_valid_i = 1'b1;
        res_taken_i = 1'b0;
        tick();
        total++; if (count_o !== 4'd1 || alloc_ready_o !== 1'b0 || idx_o !== 32'h900) begin bad++; $display("FAIL db_stall1 got cnt=%0d ready=%b idx=%h want 1 0 900", count_o, alloc_ready_o, idx_o); end
        tick();
        res_valid_i = 1'b0;
        #1;
        total++; if (count_o !== 4'd0 || alloc_ready_o !== 1'b1 || idx_o !== 32'h904) begin bad++; $display("FAIL db_drained got cnt=%0d ready=%b idx=%h want 0 1 904", count_o, alloc_ready_o, idx_o); end
        tick();
        alloc_valid_i = 1'b0;
        total++; if (count_o !== 4'd1) begin bad++; $display("FAIL db_accept got=%0d want=1", count_o); end
        do_resolve(1'b0, 32'h0);
`else
        total++; if (alloc_ready_o !== 1'b1) begin bad++; $display("FAIL db_nobarrier got ready=%b want 1", alloc_ready_o); end
        tick();
        alloc_valid_i = 1'b0;
        total++; if (count_o !== 4'd3) begin bad++; $display("FAIL db_count got=%0d want=3", count_o); end
        for (int i = 0; i < 3; i++) do_resolve(1'b0, 32'h0);
`endif
        total++; if (idx_o !== 32'hA00 || domain_o !== SUPER || count_o !== 4'd0) begin bad++; $display("FAIL db_last got idx=%h d=%0d cnt=%0d want A00 2 0", idx_o, domain_o, count_o); end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full();
        test_mispredict_dir();
        test_mispredict_targ();
        test_wrap();
        test_async_reset();
        test_domain_barrier();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end

endmodule

// File: doc/bp_resolve_queue.md
Name: bp_resolve_queue

Overview:
- Update-side partner of the TAGE predictor. Records every issued prediction in program order.
- Accepts in-order branch resolutions from execute and produces the predictor's training stream: br_result, correct, idx and domain.
- On a mispredict it flushes all younger in-flight predictions and issues a fetch redirect.
- Sits between the fetch stage, which consumes prediction_o/targ_o, and the execute stage.

Parameters:
- DEPTH, 8, number of in-flight predictions. Must be a power of two and at least 2.
- CNT_W, 16, width of the mispredict counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- alloc_valid_i  in  1  fetch offers a new prediction record
- alloc_ready_o  out  1  record accepted this cycle when valid && ready
- alloc_idx_i  in  32  branch PC
- alloc_pred_i  in  1  predicted direction
- alloc_targ_i  in  32  predicted target
- alloc_domain_i  in  domain_t  domain of the fetching context
- res_valid_i  in  1  execute resolves the oldest branch
- res_ready_o  out  1  resolution accepted when valid && ready
- res_taken_i  in  1  actual direction
- res_targ_i  in  32  actual target
- upd_valid_o  out  1  one-cycle training strobe to the predictor
- br_result_o  out  1  actual direction
- correct_o  out  1  prediction was correct
- idx_o  out  32  PC of the trained branch
- domain_o  out  domain_t  domain of the trained branch
- redirect_o  out  1  one-cycle fetch redirect pulse
- redirect_pc_o  out  32  redirect target
- count_o  out  $clog2(DEPTH+1)  occupancy
- mispred_cnt_o  out  CNT_W  saturating mispredict count

Behaviour:
- Reset:
  - State RUN; head and tail pointers 0; count 0; mispred_cnt_o 0.
  - All strobes and data outputs 0; domain_o = INIT.
  - An assertion mid-operation discards every entry immediately and emits no upd_valid_o or redirect_o pulse.
- States:
  - RUN: normal operation.
  - FLUSH: lasts exactly 1 cycle, then returns to RUN.
- Ready signals:
  - alloc_ready_o = (state==RUN) && (count<DEPTH).
  - res_ready_o = (state==RUN) && (count>0).
  - Both are derived from the registered count only. A full queue therefore refuses alloc even in a cycle that also pops.
- Alloc handshake: write {idx, pred, targ, domain} at the tail, increment the tail (wrapping mod DEPTH), increment count.
- Resolve handshake: read the head entry and compute
  - correct = (pred==res_taken_i) && (!res_taken_i || targ==res_targ_i).
- Outputs registered on the following cycle (latency 1):
  - upd_valid_o=1, br_result_o=res_taken_i, correct_o=correct, idx_o/domain_o taken from the entry.
  - Data outputs hold their values when upd_valid_o=0.
- Correct resolve: pop the head; count decrements.
  - Alloc and resolve in the same cycle leave count unchanged and move both pointers.
- Mispredict resolve:
  - Next cycle: state=FLUSH, count=0, tail=head=0.
  - redirect_o=1 with redirect_pc_o = res_taken_i ? res_targ_i : idx+4, where idx+4 wraps modulo 2^32.
  - Any alloc handshake in the same cycle is dropped, since that record is younger.
  - mispred_cnt_o increments, saturating at all-ones.
- Resolutions are strictly in order; execute never resolves a non-head branch.
- res_valid_i while count==0 is ignored (res_ready_o=0).

Optional Feature:
- Macro: BPRQ_DOMAIN_BARRIER_EN.
- Defined:
  - An alloc whose alloc_domain_i differs from the domain of the most recent accepted alloc (reset value INIT) is stalled: alloc_ready_o=0 until count==0.
  - The first alloc after a drain or reset is always accepted.
  - As a result, training updates from two domains never interleave.
- Undefined: no domain check; alloc_ready_o follows the base rule.

Decomposition:
- Shared package bp_pkg contains:
  - bprq_entry_t packed struct {idx[31:0], pred, targ[31:0], domain_t domain}.
  - bprq_state_e {RUN, FLUSH}.
  - BR_INSN_BYTES=4.
- domain_t remains from common_defines.svh.
- One sub-module, bprq_storage: DEPTH x bprq_entry_t register array with a write port and a combinational head read port, no reset on data.

Test Plan:
1. Reset, alloc 3 records (PC 0x100/0x200/0x300, pred 1,0,1), resolve all correct in order:
   - count_o 3→0.
   - Three upd_valid_o pulses with idx 0x100,0x200,0x300 and correct_o=1.
   - No redirect_o.
2. Alloc 8 records:
   - alloc_ready_o=0 at count 8.
   - Ninth alloc held with valid asserted is accepted only in the cycle after a resolve.
3. Queue of 4, head PC 0x400, pred taken/targ 0x800, resolve not-taken:
   - Next cycle upd_valid_o=1, correct_o=0, redirect_o=1, redirect_pc_o=0x404, count_o=0.
   - Then one FLUSH cycle with both readies 0.
   - mispred_cnt_o=1.
4. Head pred taken/targ 0x800, resolve taken with res_targ 0x900:
   - correct_o=0, redirect_pc_o=0x900.
   - An alloc presented in the same cycle is dropped (count_o=0 afterwards).
5. Assert rst_i asynchronously mid-cycle with count 5:
   - Outputs 0 and count_o=0 before the next clock edge.
   - No upd_valid_o after release.
6. With BPRQ_DOMAIN_BARRIER_EN, alloc 2 records in domain A, then offer a domain B record:
   - alloc_ready_o=0 until both resolve.
   - Then the B record is accepted.
